hd44780_nybbler: RTL and testbench

Byte-to-nybble transmit engine for the HD44780 character LCD in 4-bit bus mode. Clocked from the syscon's CLK_O/RST_O, it accepts one command or data byte per request over a Wishbone-like strobe/ack handshake. It drives the LCD pins with the required setup, enable-pulse, hold, inter-nybble and execution delays. It sits between the syscon and the init/command sequencer, which issues bytes and waits for ACK_O.

---
 rtl/hd44780_pkg.sv | 34 +++
 rtl/hd44780_nybbler_if.sv | 22 ++
 rtl/hd44780_delay_ctr.sv | 34 +++
 rtl/hd44780_nybbler.sv | 153 +++++++++++++++
 tb/tb_hd44780_nybbler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hd44780_pkg.sv
// Shared HD44780 definitions: transmit FSM encoding, default timing at the project clock,
// and the command opcodes the init/command sequencer issues.
package hd44780_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StEhigh,
        StHold,
        StGap,
        StExec,
        StAck
    } nyb_state_e;

    localparam int unsigned DEF_T_AS   = 2;
    localparam int unsigned DEF_T_PWEH = 12;
    localparam int unsigned DEF_T_H    = 2;
    localparam int unsigned DEF_T_GAP  = 48;
    localparam int unsigned DEF_T_EXEC = 1800;
    localparam int unsigned DEF_T_LONG = 73000;
    localparam int unsigned DEF_CNT_W  = 17;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
    localparam logic [7:0] CMD_DISPLAY_OFF  = 8'h08;
    localparam logic [7:0] CMD_FUNC_4BIT_2L = 8'h28;
    localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;
    // Sent with NYB_ONLY during power-on: wake-up (8-bit) and switch to 4-bit mode
    localparam logic [7:0] INIT_NYB_8BIT    = 8'h30;
    localparam logic [7:0] INIT_NYB_4BIT    = 8'h20;

endpackage

// File: rtl/hd44780_nybbler_if.sv
// Request/acknowledge bus between the command sequencer (master) and the nybbler (slave).
interface hd44780_nybbler_if;

    logic       STB_I;
    logic [7:0] DAT_I;
    logic       RS_I;
    logic       NYB_ONLY_I;
    logic       LONG_I;
    logic       ACK_O;
    logic       BUSY_O;

    modport master (
        output STB_I, DAT_I, RS_I, NYB_ONLY_I, LONG_I,
        input  ACK_O, BUSY_O
    );

    modport slave (
        input  STB_I, DAT_I, RS_I, NYB_ONLY_I, LONG_I,
        output ACK_O, BUSY_O
    );

endinterface

// File: rtl/hd44780_delay_ctr.sv
// Loadable down-counter that stops at zero; shared by the nybbler and the power-on sequencer.
module hd44780_delay_ctr #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             LOAD_I,
    input  logic [CNT_W-1:0] VAL_I,
    output logic             ZERO_O
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (LOAD_I) begin
            cnt_d = VAL_I;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ZERO_O = (cnt_q == '0);

endmodule

// File: rtl/hd44780_nybbler.sv
// HD44780 4-bit bus transmit engine: splits a byte into nybbles and generates E strobes
// with setup, pulse, hold, inter-nybble gap and execution delays.
module hd44780_nybbler
    import hd44780_pkg::*;
#(
    parameter int unsigned T_AS   = DEF_T_AS,
    parameter int unsigned T_PWEH = DEF_T_PWEH,
    parameter int unsigned T_H    = DEF_T_H,
    parameter int unsigned T_GAP  = DEF_T_GAP,
    parameter int unsigned T_EXEC = DEF_T_EXEC,
    parameter int unsigned T_LONG = DEF_T_LONG,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    hd44780_nybbler_if.slave         bus,
    output logic                     LCD_RS,
    output logic                     LCD_RW,
    output logic                     LCD_E,
    output logic [3:0]               LCD_DB
);

    localparam int unsigned CNT_LIM = 1 << CNT_W;

    if (T_AS < 1 || T_PWEH < 1 || T_H < 1 || T_GAP < 1 || T_EXEC < 1 || T_LONG < 1 ||
        T_AS >= CNT_LIM || T_PWEH >= CNT_LIM || T_H >= CNT_LIM || T_GAP >= CNT_LIM ||
        T_EXEC >= CNT_LIM || T_LONG >= CNT_LIM) begin : g_bad_timing
        $error("hd44780_nybbler: timing parameter out of range for CNT_W");
    end

    nyb_state_e state_q, state_d;

    logic [7:0] byte_q, byte_d;
    logic       rs_q, rs_d;
    logic       nyb_only_q, nyb_only_d;
    logic       long_q, long_d;
    logic       hi_q, hi_d;

    logic       latch;
    logic       hi_clr;
    logic       cnt_zero;
    logic       cnt_load;
    logic [CNT_W-1:0] cnt_val;

    logic       ack_q, busy_q, lcd_e_q, lcd_rs_q;
    logic [3:0] lcd_db_q;
    logic [3:0] nyb_sel;

    always_comb begin
        state_d = state_q;
        latch   = 1'b0;
        hi_clr  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.STB_I) begin
                    state_d = StSetup;
                    latch   = 1'b1;
                end
            end
            StSetup: if (cnt_zero) state_d = StEhigh;
            StEhigh: if (cnt_zero) state_d = StHold;
            StHold: begin
                if (cnt_zero) state_d = (hi_q && !nyb_only_q) ? StGap : StExec;
            end
            StGap: begin
                if (cnt_zero) begin
                    state_d = StSetup;
                    hi_clr  = 1'b1;
                end
            end
            StExec: if (cnt_zero) state_d = StAck;
            // A request present during ACK is taken immediately: back-to-back, no idle gap
            StAck: begin
                if (bus.STB_I) begin
                    state_d = StSetup;
                    latch   = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        byte_d     = latch ? bus.DAT_I      : byte_q;
        rs_d       = latch ? bus.RS_I       : rs_q;
        nyb_only_d = latch ? bus.NYB_ONLY_I : nyb_only_q;
        long_d     = latch ? bus.LONG_I     : long_q;
        hi_d       = latch ? 1'b1 : (hi_clr ? 1'b0 : hi_q);
        nyb_sel    = hi_d ? byte_d[7:4] : byte_d[3:0];
    end

    // Every state entry reloads the counter with (duration - 1)
    always_comb begin
        cnt_load = (state_d != state_q);
        cnt_val  = '0;
        unique case (state_d)
            StSetup: cnt_val = CNT_W'(T_AS - 1);
            StEhigh: cnt_val = CNT_W'(T_PWEH - 1);
            StHold:  cnt_val = CNT_W'(T_H - 1);
            StGap:   cnt_val = CNT_W'(T_GAP - 1);
            StExec:  cnt_val = long_d ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
            default: cnt_val = '0;
        endcase
    end

    hd44780_delay_ctr #(
        .CNT_W (CNT_W)
    ) u_delay_ctr (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .LOAD_I (cnt_load),
        .VAL_I  (cnt_val),
        .ZERO_O (cnt_zero)
    );

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= StIdle;
            byte_q     <= '0;
            rs_q       <= 1'b0;
            nyb_only_q <= 1'b0;
            long_q     <= 1'b0;
            hi_q       <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            lcd_e_q    <= 1'b0;
            lcd_rs_q   <= 1'b0;
            lcd_db_q   <= '0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            rs_q       <= rs_d;
            nyb_only_q <= nyb_only_d;
            long_q     <= long_d;
            hi_q       <= hi_d;
            ack_q      <= (state_d == StAck);
            busy_q     <= (state_d != StIdle);
            lcd_e_q    <= (state_d == StEhigh);
            lcd_rs_q   <= (state_d == StIdle) ? 1'b0 : rs_d;
            lcd_db_q   <= (state_d == StIdle) ? 4'h0 : nyb_sel;
        end
    end

    assign bus.ACK_O  = ack_q;
    assign bus.BUSY_O = busy_q;
    assign LCD_E      = lcd_e_q;
    assign LCD_RS     = lcd_rs_q;
    assign LCD_DB     = lcd_db_q;
    assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_hd44780_nybbler.sv
// Bench for hd44780_nybbler: directed and random transfers compared against a pulse-level
// model of the LCD bus (nybble list, E widths, ACK time).
module tb_hd44780_nybbler;

    localparam int NIB_CYC = 2 + 12 + 2;
    localparam int GAP_CYC = 48;
    localparam int EXEC_CYC = 1800;
    localparam int LONG_CYC = 73000;
    localparam int E_WIDTH = 12;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       LCD_RS, LCD_RW, LCD_E;
    logic [3:0] LCD_DB;

    hd44780_nybbler_if bus ();

    hd44780_nybbler dut (
        .CLK_I  (CLK),
        .RST_I  (RST),
        .bus    (bus),
        .LCD_RS (LCD_RS),
        .LCD_RW (LCD_RW),
        .LCD_E  (LCD_E),
        .LCD_DB (LCD_DB)
    );

    initial forever #5 CLK = ~CLK;

    int cyc = 0;
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    // Bus monitor, sampled on the falling edge
    int         e_rise[$];
    logic [3:0] e_db[$];
    logic       e_rs[$];
    int         e_wid[$];
    int         ack_cyc[$];
    int         e_bad = 0;
    int         stab_bad = 0;
    logic       prev_e = 1'b0;
    int         cur_w = 0;
    logic [3:0] cur_db = '0;
    logic       cur_rs = 1'b0;

    initial forever begin
        @(negedge CLK);
        if (LCD_E === 1'b1) begin
            if (!prev_e) begin
                e_rise.push_back(cyc);
                e_db.push_back(LCD_DB);
                e_rs.push_back(LCD_RS);
                cur_w = 1;
                cur_db = LCD_DB;
                cur_rs = LCD_RS;
            end else begin
                cur_w++;
                if (LCD_DB !== cur_db || LCD_RS !== cur_rs) stab_bad++;
            end
            if (bus.BUSY_O !== 1'b1) e_bad++;
        end else if (prev_e) begin
            e_wid.push_back(cur_w);
        end
        if (bus.ACK_O === 1'b1) ack_cyc.push_back(cyc);
        prev_e = (LCD_E === 1'b1);
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic clear_mon();
        e_rise.delete();
        e_db.delete();
        e_rs.delete();
        e_wid.delete();
        ack_cyc.delete();
    endtask

    // Issue one request, scramble inputs after acceptance, and check against the model
    task automatic xfer(input string tag, input logic [7:0] b, input logic rs, input logic nyb,
                        input logic lng, input bit mid_stb);
        int k;
        int dly;
        int n;
        logic [3:0] exp_nyb[$];
        exp_nyb.delete();
        exp_nyb.push_back(b[7:4]);
        if (!nyb) exp_nyb.push_back(b[3:0]);
        n = exp_nyb.size();
        dly = n * NIB_CYC + (n == 2 ? GAP_CYC : 0) + (lng ? LONG_CYC : EXEC_CYC);

        clear_mon();
        bus.DAT_I = b;
        bus.RS_I = rs;
        bus.NYB_ONLY_I = nyb;
        bus.LONG_I = lng;
        bus.STB_I = 1'b1;
        tick();
        k = cyc;
        bus.STB_I = 1'b0;
        bus.DAT_I = ~b;
        bus.RS_I = ~rs;
        bus.NYB_ONLY_I = ~nyb;
        bus.LONG_I = ~lng;
        check({tag, " busy_at_accept"}, bus.BUSY_O, 1);

        for (int i = 0; i < dly + 50 && ack_cyc.size() == 0; i++) begin
            bus.STB_I = mid_stb && (i == 40);
            if (bus.STB_I) bus.DAT_I = 8'($urandom);
            tick();
        end
        bus.STB_I = 1'b0;
        repeat (3) tick();

        check({tag, " e_pulses"}, e_rise.size(), n);
        for (int i = 0; i < n && i < e_rise.size(); i++) begin
            check($sformatf("%s db[%0d]", tag, i), e_db[i], exp_nyb[i]);
            check($sformatf("%s rs[%0d]", tag, i), e_rs[i], rs);
            if (i < e_wid.size()) check($sformatf("%s ewid[%0d]", tag, i), e_wid[i], E_WIDTH);
        end
        if (e_rise.size() > 0) check({tag, " e_rise0"}, e_rise[0], k + 2);
        if (n == 2 && e_rise.size() > 1) check({tag, " e_rise1"}, e_rise[1], k + NIB_CYC + GAP_CYC + 2);
        check({tag, " ack_count"}, ack_cyc.size(), 1);
        if (ack_cyc.size() > 0) check({tag, " ack_time"}, ack_cyc[0] - k, dly);
        check({tag, " busy_after"}, bus.BUSY_O, 0);
        check({tag, " e_stable"}, stab_bad, 0);
        check({tag, " e_only_busy"}, e_bad, 0);
    endtask

    initial begin
        int bad;
        int k1;
        int a;
        logic [7:0] b1, b2;

        bus.STB_I = 1'b0;
        bus.DAT_I = '0;
        bus.RS_I = 1'b0;
        bus.NYB_ONLY_I = 1'b0;
        bus.LONG_I = 1'b0;

        RST = 1'b1;
        repeat (5) tick();
        check("rst ack", bus.ACK_O, 0);
        check("rst busy", bus.BUSY_O, 0);
        check("rst e", LCD_E, 0);
        check("rst rs", LCD_RS, 0);
        check("rst db", LCD_DB, 0);
        check("rst rw", LCD_RW, 0);

        RST = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.ACK_O !== 1'b0 || bus.BUSY_O !== 1'b0 || LCD_E !== 1'b0 ||
                LCD_RS !== 1'b0 || LCD_DB !== 4'h0 || LCD_RW !== 1'b0) bad++;
        end
        check("idle 100 cycles", bad, 0);

        xfer("byte_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        xfer("nyb_30", 8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
        xfer("long_01", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back: STB held high across the ACK cycle
        clear_mon();
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        bus.DAT_I = b1;
        bus.RS_I = 1'b1;
        bus.NYB_ONLY_I = 1'b0;
        bus.LONG_I = 1'b0;
        bus.STB_I = 1'b1;
        tick();
        k1 = cyc;
        a = 0;
        for (int i = 0; i < 2000 && bus.ACK_O !== 1'b1; i++) tick();
        a = cyc;
        check("b2b first_ack", a - k1, 1880);
        bus.DAT_I = b2;
        tick();
        bus.STB_I = 1'b0;
        check("b2b busy_kept", bus.BUSY_O, 1);
        for (int i = 0; i < 2000 && ack_cyc.size() < 2; i++) tick();
        repeat (5) tick();
        check("b2b ack_count", ack_cyc.size(), 2);
        if (ack_cyc.size() == 2) check("b2b second_ack", ack_cyc[1] - k1, 1881 + 1880);
        check("b2b e_pulses", e_rise.size(), 4);
        if (e_rise.size() == 4) begin
            check("b2b db0", e_db[0], b1[7:4]);
            check("b2b db1", e_db[1], b1[3:0]);
            check("b2b db2", e_db[2], b2[7:4]);
            check("b2b db3", e_db[3], b2[3:0]);
            check("b2b rise2", e_rise[2] - k1, 1881 + 2);
        end
        check("b2b busy_after", bus.BUSY_O, 0);

        // Reset during the second E pulse of 0xFF
        clear_mon();
        bus.DAT_I = 8'hFF;
        bus.RS_I = 1'b1;
        bus.STB_I = 1'b1;
        tick();
        bus.STB_I = 1'b0;
        for (int i = 0; i < 200 && e_rise.size() < 2; i++) tick();
        check("rst_mid second_e_seen", e_rise.size(), 2);
        repeat (4) tick();
        check("rst_mid e_high_before", LCD_E, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_mid e", LCD_E, 0);
        check("rst_mid busy", bus.BUSY_O, 0);
        check("rst_mid db", LCD_DB, 0);
        check("rst_mid rs", LCD_RS, 0);
        repeat (1900) tick();
        check("rst_mid no_ack", ack_cyc.size(), 0);
        xfer("after_rst", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random transfers with a stray mid-transfer strobe
        for (int r = 0; r < 2; r++) begin
            xfer($sformatf("rand%0d", r), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
